// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Controller / register-file / memory signals seen by the LDM/STM sequencer.
interface ldm_stm_seq_if;
  logic        start;
  logic        load;
  logic        up;
  logic        pre;
  logic        wback;
  logic [3:0]  rn;
  logic [31:0] base;
  logic [15:0] reglist;
  logic [31:0] mem_rdata;
  logic [31:0] rf_rd;

  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  ra;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pc_we;
  logic [31:0] pc_wd;

  modport master (
    output start, load, up, pre, wback, rn, base, reglist, mem_rdata, rf_rd,
    input  busy, done, mem_addr, mem_we, mem_wdata, ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
  );

  modport slave (
    input  start, load, up, pre, wback, rn, base, reglist, mem_rdata, rf_rd,
    output busy, done, mem_addr, mem_we, mem_wdata, ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
  );
endinterface

// File: rtl/ldm_stm_seq_lsb_enc16.sv
// Lowest-set-bit priority encoder: picks the next register to transfer.
module lsb_enc16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one word transfer per cycle, ascending addresses,
// optional base writeback. All outputs decode registered state only.
module ldm_stm_seq
  import ldm_stm_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ldm_stm_seq_if.slave  bus
);

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] final_q, final_d;
  logic        load_q, load_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  rn_q, rn_d;

  logic [3:0]  cur;
  logic        cur_valid;
  logic [4:0]  n_regs;
  logic [31:0] span;
  logic [31:0] start_addr;

  lsb_enc16 u_enc (
    .vec_i   (pending_q),
    .idx_o   (cur),
    .valid_o (cur_valid)
  );

  assign n_regs = popcount16(bus.reglist);
  assign span   = {27'b0, n_regs} * WORD_BYTES;

  // Lowest register always sits at the lowest address, whatever the direction.
  always_comb begin
    unique case ({bus.up, bus.pre})
      2'b10:   start_addr = bus.base;
      2'b11:   start_addr = bus.base + WORD_BYTES;
      2'b00:   start_addr = bus.base - span + WORD_BYTES;
      default: start_addr = bus.base - span;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      final_q   <= '0;
      load_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      rn_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      final_q   <= final_d;
      load_q    <= load_d;
      wb_en_q   <= wb_en_d;
      rn_q      <= rn_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    addr_d        = addr_q;
    final_d       = final_q;
    load_d        = load_q;
    wb_en_d       = wb_en_q;
    rn_d          = rn_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.ra        = '0;
    bus.rf_we     = 1'b0;
    bus.rf_wa     = '0;
    bus.rf_wd     = '0;
    bus.pc_we     = 1'b0;
    bus.pc_wd     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pending_d = bus.reglist;
          load_d    = bus.load;
          rn_d      = bus.rn;
          wb_en_d   = bus.wback & ~(bus.load & bus.reglist[bus.rn]);
          addr_d    = start_addr;
          final_d   = bus.up ? bus.base + span : bus.base - span;
          state_d   = (n_regs != 5'd0) ? XFER : DONE;
        end
      end
      XFER: begin
        bus.mem_addr = addr_q;
        if (cur_valid) begin
          if (!load_q) begin
            bus.ra        = cur;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.rf_rd;
          end else if (cur == 4'd15) begin
            bus.pc_we = 1'b1;
            bus.pc_wd = bus.mem_rdata;
          end else begin
            bus.rf_we = 1'b1;
            bus.rf_wa = cur;
            bus.rf_wd = bus.mem_rdata;
          end
        end
        pending_d = pending_q & ~(16'b1 << cur);
        addr_d    = addr_q + WORD_BYTES;
        if (pending_d == 16'b0) state_d = wb_en_q ? WB : DONE;
      end
      WB: begin
        bus.rf_we = 1'b1;
        bus.rf_wa = rn_q;
        bus.rf_wd = final_q;
        state_d   = DONE;
      end
      default: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: cycle-by-cycle expected strobes per transfer.
module tb_ldm_stm_seq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ldm_stm_seq_if bus ();

  ldm_stm_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] rf_f(input logic [3:0] r);
    return 32'hC0DE_0000 | {28'b0, r};
  endfunction

  assign bus.mem_rdata = mem_f(bus.mem_addr);
  assign bus.rf_rd     = rf_f(bus.ra);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic busy, input logic done,
                     input logic mwe, input logic [31:0] maddr, input logic [3:0] ra,
                     input logic rwe, input logic [3:0] rwa, input logic [31:0] rwd,
                     input logic pwe, input logic [31:0] pwd);
    check({tag, ".busy"},     {31'b0, bus.busy},   {31'b0, busy});
    check({tag, ".done"},     {31'b0, bus.done},   {31'b0, done});
    check({tag, ".mem_we"},   {31'b0, bus.mem_we}, {31'b0, mwe});
    check({tag, ".mem_addr"}, bus.mem_addr,        maddr);
    check({tag, ".ra"},       {28'b0, bus.ra},     {28'b0, ra});
    check({tag, ".rf_we"},    {31'b0, bus.rf_we},  {31'b0, rwe});
    check({tag, ".rf_wa"},    {28'b0, bus.rf_wa},  {28'b0, rwa});
    check({tag, ".rf_wd"},    bus.rf_wd,           rwd);
    check({tag, ".pc_we"},    {31'b0, bus.pc_we},  {31'b0, pwe});
    check({tag, ".pc_wd"},    bus.pc_wd,           pwd);
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a negedge while IDLE; start is sampled at the next posedge.
  task automatic launch(input logic ld, input logic u, input logic p, input logic w,
                        input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
    bus.load = ld; bus.up = u; bus.pre = p; bus.wback = w;
    bus.rn = rn; bus.base = base; bus.reglist = list;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.start = 0; bus.load = 0; bus.up = 0; bus.pre = 0; bus.wback = 0;
    bus.rn = 0; bus.base = 0; bus.reglist = 0;
    reset = 1'b1;
    #2;
    idle_chk("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_chk("idle0");

    // STM IA base 0x100 {r0,r1,r3} W=1, rn=13
    launch(0, 1, 0, 1, 4'd13, 32'h100, 16'h000B);
    chk("stm_ia.c1", 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("stm_ia.c1.wdata", bus.mem_wdata, rf_f(4'd0));
    @(negedge clk);
    chk("stm_ia.c2", 1, 0, 1, 32'h104, 1, 0, 0, 0, 0, 0);
    check("stm_ia.c2.wdata", bus.mem_wdata, rf_f(4'd1));
    @(negedge clk);
    chk("stm_ia.c3", 1, 0, 1, 32'h108, 3, 0, 0, 0, 0, 0);
    check("stm_ia.c3.wdata", bus.mem_wdata, rf_f(4'd3));
    @(negedge clk);
    chk("stm_ia.wb", 1, 0, 0, 0, 0, 1, 13, 32'h10C, 0, 0);
    @(negedge clk);
    chk("stm_ia.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_chk("stm_ia.idle");

    // LDM DB base 0x200 {r4,r5} W=1, rn=1; launched in first IDLE cycle after DONE
    launch(1, 0, 1, 1, 4'd1, 32'h200, 16'h0030);
    chk("ldm_db.c1", 1, 0, 0, 32'h1F8, 0, 1, 4, mem_f(32'h1F8), 0, 0);
    @(negedge clk);
    chk("ldm_db.c2", 1, 0, 0, 32'h1FC, 0, 1, 5, mem_f(32'h1FC), 0, 0);
    @(negedge clk);
    chk("ldm_db.wb", 1, 0, 0, 0, 0, 1, 1, 32'h1F8, 0, 0);
    @(negedge clk);
    chk("ldm_db.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_chk("ldm_db.idle");

    // LDM IB base 0x40 {r2,r15} W=0
    launch(1, 1, 1, 0, 4'd0, 32'h40, 16'h8004);
    chk("ldm_ib.c1", 1, 0, 0, 32'h44, 0, 1, 2, mem_f(32'h44), 0, 0);
    @(negedge clk);
    chk("ldm_ib.pc", 1, 0, 0, 32'h48, 0, 0, 0, 0, 1, mem_f(32'h48));
    @(negedge clk);
    chk("ldm_ib.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_chk("ldm_ib.idle");

    // LDM IA rn=2 {r1,r2} W=1: loaded r2 wins, no WB
    launch(1, 1, 0, 1, 4'd2, 32'h300, 16'h0006);
    chk("ldm_rn.c1", 1, 0, 0, 32'h300, 0, 1, 1, mem_f(32'h300), 0, 0);
    @(negedge clk);
    chk("ldm_rn.c2", 1, 0, 0, 32'h304, 0, 1, 2, mem_f(32'h304), 0, 0);
    @(negedge clk);
    chk("ldm_rn.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_chk("ldm_rn.idle");

    // STM DA base 0x80 {r2,r7,r9} W=1 rn=6: addresses 0x78..0x80, base -> 0x74
    launch(0, 0, 0, 1, 4'd6, 32'h80, 16'h0284);
    chk("stm_da.c1", 1, 0, 1, 32'h78, 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stm_da.c2", 1, 0, 1, 32'h7C, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stm_da.c3", 1, 0, 1, 32'h80, 9, 0, 0, 0, 0, 0);
    check("stm_da.c3.wdata", bus.mem_wdata, rf_f(4'd9));
    @(negedge clk);
    chk("stm_da.wb", 1, 0, 0, 0, 0, 1, 6, 32'h74, 0, 0);
    @(negedge clk);
    chk("stm_da.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // STM IA across the 2^32 wrap: {r0,r1} base 0xFFFFFFFC, base -> 0x4
    launch(0, 1, 0, 1, 4'd3, 32'hFFFF_FFFC, 16'h0003);
    chk("wrap.c1", 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap.c2", 1, 0, 1, 32'h0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap.wb", 1, 0, 0, 0, 0, 1, 3, 32'h4, 0, 0);
    @(negedge clk);
    chk("wrap.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Empty list W=1: DONE one cycle after start, no strobes
    launch(0, 1, 0, 1, 4'd5, 32'h500, 16'h0000);
    chk("empty.done", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idle_chk("empty.idle");

    // STM of 8 registers, start held high while busy, reset in XFER cycle 3
    bus.load = 0; bus.up = 1; bus.pre = 0; bus.wback = 1;
    bus.rn = 4'd12; bus.base = 32'h1000; bus.reglist = 16'h00FF;
    bus.start = 1'b1;
    @(negedge clk);
    chk("stm8.c1", 1, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stm8.c2", 1, 0, 1, 32'h1004, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stm8.c3", 1, 0, 1, 32'h1008, 2, 0, 0, 0, 0, 0);
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #1;
    idle_chk("stm8.abort");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_chk("stm8.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Block-transfer sequencer for LDM/STM in the multicycle ARM datapath. It sits between the main controller, the register file and data memory. On a start pulse it walks the 16-bit register list lowest-index first and issues one word transfer per cycle. For stores it drives register-file read addresses; for loads it drives register-file or PC writes. It then optionally writes back the updated base register.

## Interface
- WORD_BYTES, 4, address increment per transferred register
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request from controller; sampled only in IDLE
- load  in  1  1 = LDM, 0 = STM (L bit)
- up  in  1  U bit, 1 = increment
- pre  in  1  P bit, 1 = before
- wback  in  1  W bit
- rn  in  4  base register index
- base  in  32  value of Rn, sampled at start
- reglist  in  16  register list, bit i = Ri
- mem_rdata  in  32  memory read data (asynchronous read, valid same cycle as mem_addr)
- rf_rd  in  32  register-file read data for ra
- busy  out  1  high from cycle after accepted start through DONE
- done  out  1  one-cycle pulse in DONE
- mem_addr  out  32  transfer address
- mem_we  out  1  memory write strobe (STM)
- mem_wdata  out  32  = rf_rd
- ra  out  4  register-file read index
- rf_we  out  1  register-file write enable
- rf_wa  out  4  register-file write index
- rf_wd  out  32  register-file write data
- pc_we  out  1  PC write enable (LDM including R15)
- pc_wd  out  32  PC write data

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE + start: latch pending = reglist, load, wback, rn.
  - Compute N = popcount(reglist); all address arithmetic is mod 2^32.
  - Start address: IA = base; IB = base+4; DA = base−4N+4; DB = base−4N.
  - Final base: up ? base+4N : base−4N.
  - Next state: XFER if N>0, else DONE.
- XFER, one cycle per register:
  - cur = lowest set bit of pending; mem_addr = addr.
  - STM: ra = cur, mem_we = 1.
  - LDM with cur≠15: rf_we = 1, rf_wa = cur, rf_wd = mem_rdata.
  - LDM with cur=15: pc_we = 1, pc_wd = mem_rdata; rf_we = 0.
  - Each cycle: clear bit cur, addr += 4.
  - When pending becomes empty: go to WB if wb_en, else DONE.
- wb_en = wback AND NOT (load AND reglist[rn]). For LDM with Rn in the list, the loaded value wins and writeback is suppressed.
- Empty list: no transfers, no writeback, straight to DONE.
- WB: rf_we = 1, rf_wa = rn, rf_wd = final base; then DONE.
- DONE: done = 1; then IDLE.
- start while not IDLE is ignored.
- Strobes (mem_we, rf_we, pc_we) are high only in the states above; otherwise 0.
- Memory order is always ascending: lowest register at lowest address.

## Timing
- Reset (async, immediate): state IDLE, pending 0, all outputs 0. A reset mid-transfer aborts with no further strobes.
- Idle outputs: busy = 0, done = 0, mem_addr = 0, ra = 0, rf_wa = 0, rf_wd = 0, pc_wd = 0.
- start sampled at edge E0. Cycles after E0: XFER 1..N, WB N+1 (if wb_en), DONE next, IDLE after that.
- Total latency start→done: N+1 cycles without WB, N+2 with WB. Empty list: 1 cycle.
- All strobes are Moore outputs from registered state/pending/addr.
- Address and data are stable for the whole cycle. Writes commit at the next rising edge.
- A new start is accepted in the first IDLE cycle after DONE.

## Structure
- Package ldm_stm_pkg:
  - state enum {IDLE, XFER, WB, DONE}
  - WORD_BYTES constant
  - popcount16 function
- Sub-module lsb_enc16: 16-bit lowest-set-bit priority encoder producing a 4-bit index and a valid flag. Used for cur.
- Top level muxes rf_wa/rf_wd between XFER and WB.

## Test plan
- STM IA, base 0x100, list {r0,r1,r3}, W=1:
  - mem_we on 0x100/0x104/0x108 with ra 0,1,3.
  - WB writes r_rn = 0x10C.
  - done on cycle 5.
- LDM DB, base 0x200, list {r4,r5}, W=1:
  - rf writes r4←M[0x1F8], r5←M[0x1FC].
  - WB writes 0x1F8.
  - done on cycle 4.
- LDM IB, base 0x40, list {r2,r15}:
  - r2←M[0x44].
  - pc_we with M[0x48], rf_we low that cycle.
  - no WB.
- LDM IA, rn=2, list {r1,r2}, W=1:
  - r2 ends with the loaded value.
  - no WB cycle; done on cycle 3.
- Empty list, W=1:
  - no strobes; done pulses 1 cycle after start.
- STM of 8 registers, reset asserted in XFER cycle 3:
  - all strobes drop immediately, busy = 0.
  - start held high during busy is ignored.
